// File: rtl/and16_response_checker.sv
// Response checker for the 16-bit AND datapath.
// Recomputes a & b for each accepted vector, counts mismatches, records the
// first failure and compacts every observed output into a MISR signature.
module and16_response_checker #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_act,
  output logic [WIDTH-1:0] signature
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] fidx_q, fidx_d;
  logic [WIDTH-1:0] fexp_q, fexp_d;
  logic [WIDTH-1:0] fact_q, fact_d;
  logic [WIDTH-1:0] sig_q, sig_d;

  logic [WIDTH-1:0] expected;
  logic             mismatch;
  logic             fb;

  // Next-state, counter, first-failure capture and signature update
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    vec_d    = vec_q;
    err_d    = err_q;
    fidx_d   = fidx_q;
    fexp_d   = fexp_q;
    fact_d   = fact_q;
    sig_d    = sig_q;
    expected = a & b;
    mismatch = (out != expected);
    fb       = sig_q[WIDTH-1] ^ sig_q[WIDTH-2] ^ sig_q[WIDTH-4] ^ sig_q[3];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          num_d   = num_vectors;
          vec_d   = '0;
          err_d   = '0;
          fidx_d  = '0;
          fexp_d  = '0;
          fact_d  = '0;
          sig_d   = '1;
          // An empty run completes immediately with nothing to check
          state_d = (num_vectors == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          vec_d = vec_q + 1'b1;
          sig_d = {sig_q[WIDTH-2:0], fb} ^ out;
          if (mismatch) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            if (err_q == '0) begin
              fidx_d = vec_q;
              fexp_d = expected;
              fact_d = out;
            end
          end
          if (vec_d == num_q) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      fexp_q  <= '0;
      fact_q  <= '0;
      sig_q   <= '1;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fexp_q  <= fexp_d;
      fact_q  <= fact_d;
      sig_q   <= sig_d;
    end
  end

  assign in_ready      = (state_q == S_RUN);
  assign busy          = (state_q == S_RUN);
  assign done          = (state_q == S_DONE);
  assign pass          = (state_q == S_DONE) && (err_q == '0);
  assign vec_count     = vec_q;
  assign err_count     = err_q;
  assign first_err_idx = fidx_q;
  assign first_err_exp = fexp_q;
  assign first_err_act = fact_q;
  assign signature     = sig_q;

endmodule

// File: tb/tb_and16_response_checker.sv
// Directed bench for and16_response_checker: a default-width instance and a
// CNT_W=2 instance for error-count saturation.
module tb_and16_response_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] a, b, o;

  logic        start;
  logic [7:0]  nv;
  logic        in_ready, busy, done, pass;
  logic [7:0]  vec_count, err_count, fidx;
  logic [15:0] fexp, fact, sig;

  logic        s_start;
  logic [1:0]  s_nv;
  logic        s_in_ready, s_busy, s_done, s_pass;
  logic [1:0]  s_vec_count, s_err_count, s_fidx;
  logic [15:0] s_fexp, s_fact, s_sig;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [15:0] va [6] = '{16'h0000, 16'h0000, 16'hFFFF, 16'hAAAA, 16'h3CC3, 16'h1234};
  logic [15:0] vb [6] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h5555, 16'h0FF0, 16'h9876};
  logic [15:0] vo [6] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0CC0, 16'h1034};

  always #5 clk = ~clk;

  and16_response_checker #(.WIDTH(16), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .num_vectors(nv),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .out(o),
    .busy(busy), .done(done), .pass(pass), .vec_count(vec_count),
    .err_count(err_count), .first_err_idx(fidx), .first_err_exp(fexp),
    .first_err_act(fact), .signature(sig)
  );

  and16_response_checker #(.WIDTH(16), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .start(s_start), .num_vectors(s_nv),
    .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b), .out(o),
    .busy(s_busy), .done(s_done), .pass(s_pass), .vec_count(s_vec_count),
    .err_count(s_err_count), .first_err_idx(s_fidx), .first_err_exp(s_fexp),
    .first_err_act(s_fact), .signature(s_sig)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] v);
    logic fbit;
    fbit = s[15] ^ s[14] ^ s[12] ^ s[3];
    return {s[14:0], fbit} ^ v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] n);
    start = 1'b1;
    nv    = n;
    tick();
    start = 1'b0;
  endtask

  // One cycle with a vector presented; valid drops only if no vector follows
  task automatic send(input logic [15:0] ia, input logic [15:0] ib, input logic [15:0] io);
    in_valid = 1'b1;
    a = ia; b = ib; o = io;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] es;
    reset = 1'b1; start = 1'b0; nv = '0; in_valid = 1'b0;
    a = '0; b = '0; o = '0; s_start = 1'b0; s_nv = '0;
    tick(); tick();
    reset = 1'b0;

    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_sig",   {16'd0, sig}, 32'h0000FFFF);

    // Reset mid-run
    pulse_start(8'd6);
    check("mr_busy", {31'd0, busy}, 32'd1);
    send(16'hFFFF, 16'hFFFF, 16'h0000);
    send(16'h0000, 16'h0000, 16'h0000);
    send(16'h1111, 16'h1111, 16'h1111);
    check("mr_vec_before", {24'd0, vec_count}, 32'd3);
    check("mr_err_before", {24'd0, err_count}, 32'd1);
    do_reset();
    check("mr_ready", {31'd0, in_ready}, 32'd0);
    check("mr_busy_after", {31'd0, busy}, 32'd0);
    check("mr_vec", {24'd0, vec_count}, 32'd0);
    check("mr_err", {24'd0, err_count}, 32'd0);
    check("mr_fidx", {24'd0, fidx}, 32'd0);
    check("mr_fexp", {16'd0, fexp}, 32'd0);
    check("mr_sig", {16'd0, sig}, 32'h0000FFFF);

    // Clean run, valid held high
    pulse_start(8'd6);
    es = 16'hFFFF;
    for (int i = 0; i < 6; i++) begin
      send(va[i], vb[i], vo[i]);
      es = misr(es, vo[i]);
      if (i < 5) check("clean_vec", {24'd0, vec_count}, i + 1);
    end
    check("clean_ready", {31'd0, in_ready}, 32'd0);
    check("clean_done", {31'd0, done}, 32'd1);
    check("clean_vec_final", {24'd0, vec_count}, 32'd6);
    check("clean_err", {24'd0, err_count}, 32'd0);
    check("clean_pass", {31'd0, pass}, 32'd1);
    check("clean_sig", {16'd0, sig}, {16'd0, es});
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    check("clean_hold_vec", {24'd0, vec_count}, 32'd6);

    // Injected faults at vectors 3 and 5
    pulse_start(8'd6);
    check("flt_cleared", {24'd0, vec_count}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      logic [15:0] ov;
      ov = vo[i];
      if (i == 3) ov = 16'h0001;
      if (i == 5) ov = 16'h0000;
      send(va[i], vb[i], ov);
    end
    check("flt_err", {24'd0, err_count}, 32'd2);
    check("flt_fidx", {24'd0, fidx}, 32'd3);
    check("flt_fexp", {16'd0, fexp}, 32'h0000);
    check("flt_fact", {16'd0, fact}, 32'h0001);
    check("flt_pass", {31'd0, pass}, 32'd0);
    check("flt_done", {31'd0, done}, 32'd1);

    // Backpressure gaps, start pulsed mid-run
    pulse_start(8'd3);
    begin
      logic [5:0] pat;
      int exp_v [6] = '{1, 1, 1, 2, 2, 3};
      pat = 6'b101001;
      for (int i = 0; i < 6; i++) begin
        in_valid = pat[i];
        a = 16'hF0F0; b = 16'hFF00; o = 16'hF000;
        if (i == 2) begin start = 1'b1; nv = 8'd7; end
        tick();
        start = 1'b0;
        check("bp_vec", {24'd0, vec_count}, exp_v[i]);
      end
      in_valid = 1'b0;
    end
    check("bp_done", {31'd0, done}, 32'd1);
    check("bp_pass", {31'd0, pass}, 32'd1);

    // Zero-length run, then a single vector
    pulse_start(8'd0);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_pass", {31'd0, pass}, 32'd1);
    check("zero_vec", {24'd0, vec_count}, 32'd0);
    pulse_start(8'd1);
    check("one_sig_init", {16'd0, sig}, 32'h0000FFFF);
    send(16'hFFFF, 16'hFFFF, 16'hFFFF);
    check("one_sig", {16'd0, sig}, 32'h00000001);
    check("one_pass", {31'd0, pass}, 32'd1);
    check("one_ready", {31'd0, in_ready}, 32'd0);

    // Saturation on the CNT_W=2 instance
    s_start = 1'b1; s_nv = 2'd3;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 3; i++) send(16'hFFFF, 16'hFFFF, 16'h0000);
    check("sat_err", {30'd0, s_err_count}, 32'd3);
    check("sat_fidx", {30'd0, s_fidx}, 32'd0);
    check("sat_fexp", {16'd0, s_fexp}, 32'h0000FFFF);
    check("sat_done", {31'd0, s_done}, 32'd1);
    check("sat_pass", {31'd0, s_pass}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
